alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: x, y  input  WIDTH  operands.
REQ-007 SHALL have port: zx, nx, zy, ny, f, no  input  1 each  Hack-style control bits.
REQ-008 SHALL have port: mode  input  1  0 = Hack function, 1 = multiply.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: out  output  WIDTH  registered result.
REQ-012 SHALL have port: zr, ng, ovf  output  1 each  registered flags (zero, negative, overflow).

Function
REQ-013 SHALL implement FSM states IDLE, MUL, HOLD; in_ready = 1 only in IDLE.
REQ-014 SHALL accept an operation when in_valid && in_ready; x, y, control bits, mode captured that edge.
REQ-015 SHALL preprocess operands: x' = zx ? 0 : x, then nx ? ~x'; same for y' with zy/ny.
REQ-016 mode 0: SHALL compute r = f ? x'+y' (mod 2^WIDTH) : x'&y', then no ? ~r; register result, IDLE -> HOLD; out_valid asserted the cycle after acceptance (latency 1).
REQ-017 mode 0 ovf: carry-out of x'+y' when f=1; 0 when f=0.
REQ-018 mode 1: SHALL compute unsigned x'*y' by iterative shift-add, one multiplier bit per cycle, IDLE -> MUL -> HOLD; exactly WIDTH cycles in MUL; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-019 mode 1 result: low WIDTH product bits, then no ? ~; f ignored; ovf = 1 iff any upper WIDTH product bit nonzero.
REQ-020 zr SHALL be 1 iff final out == 0; ng SHALL equal out[WIDTH-1]; both computed on the final value.
REQ-021 HOLD: out_valid = 1; out, zr, ng, ovf SHALL stay stable until out_ready; on out_valid && out_ready -> IDLE.
REQ-022 in_valid while not in IDLE SHALL be ignored (no queueing); no accept in the same cycle as result handoff.
REQ-023 out/flags SHALL only change on transition into HOLD or on reset; intermediate MUL values not visible.
REQ-024 MUL cycle counter SHALL be clog2(WIDTH+1) bits and terminate exactly at WIDTH; no wrap.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, out=0, zr=0, ng=0, ovf=0, counter/accumulator=0.
REQ-026 reset during MUL or HOLD SHALL abort the operation; result discarded; first accept possible on first rising edge after reset deasserts.

Structure
REQ-027 State encoding (IDLE/MUL/HOLD) and mode encoding SHALL live in a shared package/include for reuse by the CPU datapath.
REQ-028 Operand preprocessing (zero/negate) SHALL be one sub-module, alu_pre, instantiated twice (x and y).
REQ-029 Combinational Hack function SHALL reuse existing width-generic add/and/not primitives where available.

Verification
REQ-030 WIDTH=16, x=5, y=3, ctrl 000010, mode 0 -> out_valid next cycle, out=8, zr=0, ng=0, ovf=0.
REQ-031 ctrl zx=1 nx=1 zy=1 ny=0 f=1 no=0, mode 0 -> out=0xFFFF, ng=1, zr=0; x=y=7 ctrl 010011 (x-y) -> out=0, zr=1.
REQ-032 x=0xFFFF, y=1, ctrl 000010 -> out=0, zr=1, ovf=1.
REQ-033 x=300, y=300, mode 1, ctrl all 0 -> out_valid exactly 17 cycles after accept, out=24464 (0x5F90), ovf=1; x=12,y=11 -> out=132, ovf=0.
REQ-034 out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> out/flags stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle, then accept.
REQ-035 reset asserted 5 cycles into MUL -> out_valid=0, out=0 immediately; after deassert in_ready=1 and new mode 0 op completes normally.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle Hack ALU: FSM states and operation mode.
// The CPU datapath imports these so it decodes the same values.
package alu_mc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic MODE_HACK = 1'b0;
  localparam logic MODE_MUL  = 1'b1;

endpackage

// File: rtl/alu_pre.sv
// Hack operand preprocessing: optionally zero the operand, then optionally invert it.
module alu_pre #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             z,
  input  logic             n,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] zeroed;

  assign zeroed = z ? '0 : a;
  assign o      = n ? ~zeroed : zeroed;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle Hack ALU: single-cycle Hack function or WIDTH-cycle shift-add multiply,
// with a valid/ready handshake on both sides and registered result and flags.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               no_q;

  logic [WIDTH-1:0]   xp;
  logic [WIDTH-1:0]   yp;

  alu_pre #(.WIDTH(WIDTH)) u_pre_x (.a(x), .z(zx), .n(nx), .o(xp));
  alu_pre #(.WIDTH(WIDTH)) u_pre_y (.a(y), .z(zy), .n(ny), .o(yp));

  function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] v);
    return {(v == '0), v[WIDTH-1]};
  endfunction

  // Hack function, evaluated directly on the live inputs during the accept cycle.
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   hack_r;
  logic [WIDTH-1:0]   hack_res;
  logic               hack_ovf;

  assign sum      = {1'b0, xp} + {1'b0, yp};
  assign hack_r   = f ? sum[WIDTH-1:0] : (xp & yp);
  assign hack_res = no ? ~hack_r : hack_r;
  assign hack_ovf = f & sum[WIDTH];

  // One multiplier bit per cycle; the last step's sum is registered straight into the result.
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ovf;

  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign cnt_step = cnt + 1'b1;
  assign mul_last = (cnt_step == CW'(WIDTH));
  assign mul_res  = no_q ? ~acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign mul_ovf  = |acc_step[2*WIDTH-1:WIDTH];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      no_q   <= 1'b0;
      out    <= '0;
      zr     <= 1'b0;
      ng     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            case (mode)
              MODE_HACK: begin
                out       <= hack_res;
                {zr, ng}  <= flags_of(hack_res);
                ovf       <= hack_ovf;
                state     <= ST_HOLD;
              end
              MODE_MUL: begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, xp};
                mplier <= yp;
                cnt    <= '0;
                no_q   <= no;
                state  <= ST_MUL;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt_step;
          if (mul_last) begin
            out      <= mul_res;
            {zr, ng} <= flags_of(mul_res);
            ovf      <= mul_ovf;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner sequences,
// and randomized operations against a plain-arithmetic reference model.
module tb_alu_mc;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [W-1:0]  x, y;
  logic          zx, nx, zy, ny, f, no, mode;
  logic          out_valid, out_ready;
  logic [W-1:0]  out;
  logic          zr, ng, ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_out;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   ctrl;
    logic         mode;
    logic [W-1:0] eo;
    logic         ezr;
    logic         eng;
    logic         eovf;
  } vec_t;

  vec_t tbl[9];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [W-1:0]   xp, yp, res;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    r  = v;
    xp = v.ctrl[5] ? '0 : v.x;
    if (v.ctrl[4]) xp = ~xp;
    yp = v.ctrl[3] ? '0 : v.y;
    if (v.ctrl[2]) yp = ~yp;
    if (v.mode == 1'b0) begin
      s      = {1'b0, xp} + {1'b0, yp};
      res    = v.ctrl[1] ? s[W-1:0] : (xp & yp);
      r.eovf = v.ctrl[1] & s[W];
    end else begin
      p      = (2*W)'(xp) * (2*W)'(yp);
      res    = p[W-1:0];
      r.eovf = (p >= (2*W)'(1 << W));
    end
    if (v.ctrl[0]) res = ~res;
    r.eo  = res;
    r.ezr = (res == 0);
    r.eng = res[W-1];
    return r;
  endfunction

  task automatic drive(input vec_t v);
    x = v.x; y = v.y; {zx, nx, zy, ny, f, no} = v.ctrl; mode = v.mode;
  endtask

  task automatic run_op(input vec_t v, input int stall, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 1);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, v.mode ? 32'd17 : 32'd1);
    chk({nm, " out"}, 32'(out), 32'(v.eo));
    chk({nm, " flags"}, {29'd0, zr, ng, ovf}, {29'd0, v.ezr, v.eng, v.eovf});
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({nm, " hold"}, {15'd0, out_valid, out}, {15'd0, 1'b1, v.eo});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
    last_out = v.eo;
  endtask

  initial begin
    vec_t v;
    int lat;

    tbl[0] = '{16'd5,      16'd3,      6'b000010, 1'b0, 16'd8,      1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h1234,   16'hABCD,   6'b111010, 1'b0, 16'hFFFF,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'd7,      16'd7,      6'b010011, 1'b0, 16'd0,      1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF,   16'd1,      6'b000010, 1'b0, 16'd0,      1'b1, 1'b0, 1'b1};
    tbl[4] = '{16'd300,    16'd300,    6'b000000, 1'b1, 16'h5F90,   1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'd12,     16'd11,     6'b000000, 1'b1, 16'd132,    1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'hF0F0,   16'h3C3C,   6'b000000, 1'b0, 16'h3030,   1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'd2,      16'd3,      6'b000001, 1'b1, 16'hFFF9,   1'b0, 1'b1, 1'b0};
    tbl[8] = '{16'hFFFF,   16'hFFFF,   6'b000010, 1'b1, 16'h0001,   1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; {zx, nx, zy, ny, f, no} = '0; mode = 1'b0;
    #12;
    chk("reset state", {25'd0, in_ready, out_valid, zr, ng, ovf, 2'b00}, {25'd0, 1'b1, 6'd0});
    chk("reset out", 32'(out), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tbl[i], 0, $sformatf("vec%0d", i));

    // Stall in HOLD while a new request waits; it must not be taken at handoff.
    @(negedge clk);
    drive(tbl[5]);
    in_valid = 1'b1;
    @(negedge clk);
    drive(tbl[0]);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall latency", lat, 17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall out", {13'd0, zr, ng, ovf, out}, {13'd0, 3'b000, 16'd132});
      chk("stall ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff state", {30'd0, out_valid, in_ready}, 32'd1);
    chk("handoff no accept", 32'(out), 132);
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept after idle", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'd8});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    last_out = 16'd8;

    // Abort a multiply with reset partway through.
    @(negedge clk);
    drive(tbl[4]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mul hidden", {15'd0, out_valid, out}, {15'd0, 1'b0, last_out});
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("abort out", {12'd0, in_ready, out_valid, zr, ng, out}, {12'd0, 1'b1, 3'b000, 16'd0});
    chk("abort ovf", 32'(ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(tbl[0], 0, "post reset");

    for (int i = 0; i < 150; i++) begin
      v.x    = W'($urandom);
      v.y    = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        v.x = W'($urandom_range(0, 255));
        v.y = W'($urandom_range(0, 255));
      end
      v.ctrl = 6'($urandom);
      v.mode = 1'($urandom);
      v = model(v);
      run_op(v, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
